// File: rtl/prog_mod_counter.sv
// prog_mod_counter: programmable-modulo up/down counter with one-shot mode,
// done flag and a saturating count of terminal events.
module prog_mod_counter #(
   parameter int WIDTH  = 5,
   parameter int WRAP_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              load,
   input  logic [WIDTH-1:0]  load_value,
   input  logic              enable,
   input  logic              dir,
   input  logic [WIDTH-1:0]  limit,
   input  logic              one_shot,
   output logic [WIDTH-1:0]  count,
   output logic              reached,
   output logic              done,
   output logic [WRAP_W-1:0] wrap_count
);
   typedef enum logic {RUN, DONE} state_t;
   state_t state;
   logic term;
   logic [WRAP_W-1:0] wrap_next;
   // Up mode also treats a count above a freshly lowered limit as terminal.
   always_comb begin
      term = dir ? (count == '0) : (count >= limit);
      wrap_next = (wrap_count == '1) ? wrap_count : wrap_count + 1'b1;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= RUN;
         count      <= '0;
         reached    <= 1'b0;
         done       <= 1'b0;
         wrap_count <= '0;
      end else if (clear) begin
         state      <= RUN;
         count      <= '0;
         reached    <= 1'b0;
         done       <= 1'b0;
         wrap_count <= '0;
      end else if (load) begin
         state   <= RUN;
         count   <= load_value;
         reached <= 1'b0;
         done    <= 1'b0;
      end else if (state == RUN && enable) begin
         reached <= term;
         if (term) begin
            wrap_count <= wrap_next;
            if (one_shot) begin
               state <= DONE;
               done  <= 1'b1;
            end else begin
               count <= dir ? limit : '0;
            end
         end else begin
            count <= dir ? count - 1'b1 : count + 1'b1;
         end
      end else begin
         reached <= 1'b0;
      end
   end
endmodule

// File: doc/prog_mod_counter.md
# prog_mod_counter

Parametrised programmable-modulo counter: the general-purpose successor to the fixed 0..31 wrap counter used for bit/slot timing. It adds run-time limit, up/down direction, synchronous clear and load, enable gating, a one-shot mode with a done flag, and a saturating count of terminal events. It sits in the timing/sequencing path wherever a block needs a configurable period or a single timed interval.

## Interface

- WIDTH, 5, counter width in bits; count range 0..2^WIDTH-1
- WRAP_W, 8, width of the terminal-event counter wrap_count
- clk  input  1  clock, all state changes on rising edge
- reset  input  1  asynchronous, active-high
- clear  input  1  synchronous clear, active-high
- load  input  1  synchronous load of load_value, active-high
- load_value  input  WIDTH  value written to count on load
- enable  input  1  count advance enable
- dir  input  1  0 = count up, 1 = count down
- limit  input  WIDTH  terminal value (up) / reload value (down); sampled every cycle
- one_shot  input  1  0 = free-running wrap, 1 = stop at terminal
- count  output  WIDTH  current count (registered)
- reached  output  1  one-cycle pulse per terminal event (registered)
- done  output  1  high while in DONE state (one-shot finished)
- wrap_count  output  WRAP_W  number of terminal events since reset/clear, saturating

## Operation

- Reset (async): count=0, reached=0, done=0, wrap_count=0, state=RUN.
- Per-cycle priority: reset > clear > load > counting > hold.
- clear: count=0, reached=0, done=0, wrap_count=0, state=RUN.
- load: count=load_value, reached=0, done=0, state=RUN; wrap_count unchanged.
- Hold (enable=0, or state=DONE): count unchanged, reached=0.
- Terminal condition, evaluated on current count: up: count >= limit (covers count above a lowered limit); down: count == 0.
- RUN, enable=1, not terminal: count +1 (up) or -1 (down); reached=0.
- RUN, enable=1, terminal, one_shot=0: count -> 0 (up) or limit (down); reached=1; state stays RUN.
- RUN, enable=1, terminal, one_shot=1: count holds at current value; reached=1; done=1; state -> DONE.
- DONE: exits only via clear or load (or reset); deasserting one_shot or enable does not exit.
- wrap_count: +1 on every cycle reached is set; holds at 2^WRAP_W-1 once saturated.
- limit = 0, up: terminal every enabled cycle; count stays 0, reached high each enabled cycle (free-run).
- dir changes mid-count take effect on the next enabled edge; no reload on change.
- Width rules: all arithmetic modulo 2^WIDTH; no carry out; limit and load_value unsigned.

## Timing

- All outputs are registers; no combinational input-to-output path.
- reached is high in the cycle immediately after the terminal count was sampled, coincident with count showing the restart value (free-run) or the held terminal value (one-shot).
- Period in free-run up mode = limit+1 enabled cycles; down mode = limit+1 enabled cycles.
- done rises in the same cycle as the one-shot reached pulse; falls in the cycle after clear/load is sampled.
- clear/load asserted together with a terminal event: clear/load wins, no reached pulse, wrap_count not incremented.
- reset asserted mid-count: outputs go to reset values immediately (asynchronously), no reached pulse on release.
- Defaults (WIDTH=5, limit=31, dir=0, one_shot=0, enable=1) reproduce legacy behaviour: 0..31 then 0, reached high for one cycle with count=0.

## Test plan

- Legacy mode: limit=31, dir=0, enable=1, release reset -> count 0,1..31,0; reached=1 only in the cycle count returns to 0, every 32 cycles; wrap_count increments 1,2,3.
- Down + limit: dir=1, load 5 then limit=5 -> count 5,4,3,2,1,0,5; reached=1 in cycle count shows 5 after the 0.
- One-shot: limit=3, one_shot=1, clear -> count 0,1,2,3,3,3...; reached single pulse, done=1 held; load load_value=1 -> done=0, count 1,2,3, second pulse.
- Priority/collision: count=limit with enable=1 and clear=1 same cycle -> count=0, reached=0, wrap_count=0; with load=1, load_value=7 -> count=7, no pulse.
- Enable gating and limit lowering: count at 10, limit dropped to 4 -> next enabled edge wraps to 0 with reached=1; enable=0 for 5 cycles -> count frozen, reached=0.
- Saturation and async reset: WRAP_W=2, limit=0 free-run -> wrap_count 1,2,3,3; assert reset mid-cycle -> all outputs 0 before next edge.
